// File: rtl/jmp_pkg.sv
// Shared jump-mode encodings and push/pop classification for the jump address generator.
package jmp_pkg;

    typedef enum logic [2:0] {
        JMP_ABS   = 3'b000,
        JMP_BASE  = 3'b001,
        JMP_PCREL = 3'b010,
        JMP_CALL  = 3'b011,
        JMP_CALLB = 3'b100,
        JMP_RET   = 3'b101
    } jmp_mode_t;

    function automatic logic is_push(input logic [2:0] mode);
        return (mode == JMP_CALL) || (mode == JMP_CALLB);
    endfunction

    function automatic logic is_pop(input logic [2:0] mode);
        return mode == JMP_RET;
    endfunction

endpackage

// File: rtl/jmp_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full, pop on empty is ignored.
// tos/full/empty/ovf/unf are combinational from the current state; pointer and count move on the clock edge.
module jmp_ras #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tos,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);

    localparam int PW = $clog2(STACK_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [PW-1:0]    sp_q;
    logic [CW-1:0]    cnt_q;

    assign full  = (cnt_q == CW'(STACK_DEPTH));
    assign empty = (cnt_q == '0);
    assign ovf   = push && full;
    assign unf   = pop && empty;
    // An empty stack reads as zero so an underflowing return lands on the bare offset.
    assign tos   = empty ? '0 : mem_q[sp_q - PW'(1)];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            sp_q  <= '0;
            cnt_q <= '0;
        end else if (push) begin
            mem_q[sp_q] <= din;
            sp_q        <= sp_q + PW'(1);
            if (!full) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else if (pop && !empty) begin
            sp_q  <= sp_q - PW'(1);
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/jmp_unit.sv
// Next-PC target generator with base register bank, return-address stack and sticky stack error.
// out_addr/jmp_taken are zero-latency combinational; base, stack and error state update on the rising edge; no backpressure.
module jmp_unit
    import jmp_pkg::*;
#(
    parameter int  WIDTH       = 8,
    parameter int  NUM_BASE    = 2,
    parameter int  STACK_DEPTH = 4,
    localparam int SEL_W       = (NUM_BASE > 1) ? $clog2(NUM_BASE) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jmp_en,
    input  logic [2:0]       jmp_mode,
    input  logic [SEL_W-1:0] base_sel,
    input  logic             base_ld,
    input  logic [WIDTH-1:0] base_data,
    input  logic [WIDTH-1:0] offset,
    input  logic [WIDTH-1:0] pc_ret,
    output logic [WIDTH-1:0] out_addr,
    output logic             jmp_taken,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err,
    input  logic             err_clr
);

    logic [WIDTH-1:0] base_q [NUM_BASE];
    logic [WIDTH-1:0] base_rd;
    logic [WIDTH-1:0] tos;
    logic             mode_vld;
    logic             ras_push;
    logic             ras_pop;
    logic             ras_ovf;
    logic             ras_unf;
    logic             err_q;
    logic             err_d;

    assign mode_vld = jmp_en && (jmp_mode <= JMP_RET);
    assign ras_push = mode_vld && is_push(jmp_mode);
    assign ras_pop  = mode_vld && is_pop(jmp_mode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BASE; i++) begin
                base_q[i] <= '0;
            end
        end else if (base_ld) begin
            for (int i = 0; i < NUM_BASE; i++) begin
                if (base_sel == SEL_W'(i)) begin
                    base_q[i] <= base_data;
                end
            end
        end
    end

    // Out-of-range selects (non power-of-two bank) read as zero.
    always_comb begin
        base_rd = '0;
        for (int i = 0; i < NUM_BASE; i++) begin
            if (base_sel == SEL_W'(i)) begin
                base_rd = base_q[i];
            end
        end
    end

    always_comb begin
        out_addr  = pc_ret;
        jmp_taken = mode_vld;
        if (jmp_en) begin
            case (jmp_mode)
                JMP_ABS, JMP_CALL:   out_addr = offset;
                JMP_BASE, JMP_CALLB: out_addr = base_rd + offset;
                JMP_PCREL:           out_addr = pc_ret + offset;
                JMP_RET:             out_addr = tos + offset;
                default:             out_addr = pc_ret;
            endcase
        end
    end

    jmp_ras #(
        .WIDTH       (WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_ret),
        .tos   (tos),
        .full  (stack_full),
        .empty (stack_empty),
        .ovf   (ras_ovf),
        .unf   (ras_unf)
    );

    // A fresh error in the same cycle as a clear keeps the flag set.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (ras_ovf || ras_unf) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign stack_err = err_q;

endmodule

// File: doc/jmp_unit.md
Name: jmp_unit

Overview:
- Next-generation jump address generator for the single-cycle CPU.
- Computes the next-PC target for absolute, base-relative, PC-relative, CALL and RET instructions.
- Holds a bank of base address registers and a hardware return-address stack (RAS), so nested calls work without a single link register.
- Sits between the decoder and the PC mux. out_addr is combinational; all state updates on the clock edge.

Parameters:
- WIDTH, 8, address/data width in bits.
- NUM_BASE, 2, number of base address registers (>=1).
- STACK_DEPTH, 4, RAS entries (power of two, >=2).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- jmp_en  input  1  current instruction is a jump-class instruction.
- jmp_mode  input  3  jump mode, encodings below.
- base_sel  input  $clog2(NUM_BASE) (min 1)  selects the base register for base modes and for loads.
- base_ld  input  1  write base_data into BASE[base_sel] at the next clock edge.
- base_data  input  WIDTH  value to load into the base register.
- offset  input  WIDTH  immediate target or offset.
- pc_ret  input  WIDTH  address of the following instruction (PC+1); this is the fall-through and the value pushed on CALL.
- out_addr  output  WIDTH  next-PC target.
- jmp_taken  output  1  out_addr must be used by the PC mux.
- stack_full  output  1  RAS count == STACK_DEPTH.
- stack_empty  output  1  RAS count == 0.
- stack_err  output  1  sticky flag: RAS overflow or underflow occurred.
- err_clr  input  1  synchronous clear of stack_err.

Behaviour:
- Modes, valid only when jmp_en=1:
  - 000 ABS: out=offset.
  - 001 BASE: out=BASE[sel]+offset.
  - 010 PCREL: out=pc_ret+offset.
  - 011 CALL: out=offset; push pc_ret.
  - 100 CALLB: out=BASE[sel]+offset; push pc_ret.
  - 101 RET: out=TOS+offset; pop.
  - 110/111 reserved: jmp_taken=0, out=pc_ret, no state change.
- jmp_en=0: out_addr=pc_ret and jmp_taken=0, regardless of mode.
- jmp_taken is 1 for every valid mode when jmp_en=1.
- All additions are modulo 2^WIDTH. Carry is discarded; there is no overflow flag for address arithmetic.
- out_addr and jmp_taken are purely combinational (zero latency). Stack and base updates take effect at the following rising edge.
- base_ld is a synchronous write enable sampled on clk, not an edge-triggered strobe.
  - If base_ld coincides with a BASE/CALLB jump using the same register, the jump uses the old value; the new value is visible from the next cycle.
  - base_ld is independent of jmp_en.
- RAS is a circular buffer with a write pointer sp (log2 depth bits) and count (0..STACK_DEPTH). TOS = mem[sp-1].
- Push with count<STACK_DEPTH: mem[sp]<=pc_ret, sp++, count++.
- Push when full (overflow):
  - Write mem[sp], sp++ (wraps), so the oldest entry is overwritten.
  - count stays STACK_DEPTH and stack_err<=1.
  - out_addr is still computed normally.
- Pop with count>0: sp--, count--.
- Pop when empty (underflow):
  - TOS is treated as 0, so out=offset.
  - sp and count are unchanged, stack_err<=1.
  - jmp_taken=1.
- Only one push or pop can occur per cycle, because mode is single-valued.
- err_clr clears stack_err. If a new error occurs in the same cycle, set wins over clear.
- Reset (async):
  - all BASE regs=0, all mem=0, sp=0, count=0, stack_err=0.
  - Hence stack_empty=1 and stack_full=0.
  - Outputs follow combinationally from the inputs and the reset state.
  - Reset asserted mid-call discards the whole stack immediately.

Decomposition:
- Package jmp_pkg holds:
  - the jmp_mode_t 3-bit encodings (JMP_ABS, JMP_BASE, JMP_PCREL, JMP_CALL, JMP_CALLB, JMP_RET);
  - a helper function is_push(mode) / is_pop(mode).
- Sub-module jmp_ras (return-address stack):
  - parameters WIDTH and STACK_DEPTH;
  - ports clk, rst, push, pop, din, tos, full, empty, ovf, unf.
- jmp_unit contains the base register bank, the target mux/adder, and the sticky error logic.

Test Plan:
- Reset, then ABS with offset=0x3C, jmp_en=1 -> out=0x3C, jmp_taken=1, stack_empty=1, stack_err=0.
- base_ld with sel=1, data=0xF0, then BASE with sel=1, offset=0x20 next cycle -> out=0x10 (wrap). A BASE jump in the same cycle as the load -> out=0x20 (old value 0).
- Nested calls: CALL pushes pc_ret=0x05, 0x11, 0x22; RET, RET, RET with offset=0 -> out=0x22, 0x11, 0x05, then stack_empty=1, stack_err=0.
- Overflow (depth 4): push 0x01..0x05 -> stack_full=1, stack_err=1. Four RETs yield 0x05, 0x04, 0x03, 0x02.
- Underflow: RET on an empty stack with offset=0x07 -> out=0x07, stack_err=1. err_clr -> stack_err=0 next cycle.
- PCREL with pc_ret=0xFE, offset=0x04 -> out=0x02. Mode 110 -> jmp_taken=0, out=pc_ret. Asserting rst after two CALLs -> stack_empty=1 immediately.
